// File: rtl/zoom_in_nni_scanner.sv
// Nearest-neighbour zoom-in scanner: copies src(x>>k, y>>k) to dst(x, y) for every pixel in raster order.
// Latency: one read per cycle from the cycle after start; write of pixel i lands RD_LATENCY cycles after its read; done one cycle after the last write.
// Backpressure: none; both RAMs must accept one access per cycle, and start is ignored unless the engine is idle.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   start, fator_zoom    frame request (sampled in IDLE) and zoom select (00=1x, 01=2x, 10=4x, 11=1x)
//   busy, done           frame in progress / one-cycle completion pulse
//   rd_en, rd_addr       source RAM read port; rd_data returns RD_LATENCY cycles later
//   wr_en, wr_addr       destination RAM write port; wr_data is rd_data passed through
module zoom_in_nni_scanner #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        fator_zoom,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        zoom_q;
  logic [1:0]        k;
  logic [XW-1:0]     x_q, x_inc;
  logic [YW-1:0]     y_q, y_inc;
  logic [ADDR_W-1:0] row_base_q, row_base_nxt;
  logic [ADDR_W-1:0] dst_addr_q;
  logic [ADDR_W-1:0] src_nxt;
  logic              row_wrap, last_pix, row_step;
  logic              accept;

  // Tag pipeline: carries the destination address alongside each outstanding read.
  logic [RD_LATENCY-1:0] tag_vld;
  logic [RD_LATENCY-1:0] tag_early;
  logic [ADDR_W-1:0]     tag_addr [RD_LATENCY];

  assign accept = (state_q == S_IDLE) && start;

  // Shift amount from the latched zoom; 11 falls back to 1x.
  always_comb begin
    k = 2'd0;
    if (zoom_q == 2'b01) k = 2'd1;
    else if (zoom_q == 2'b10) k = 2'd2;
  end

  // Next source address, built from the current row base without a multiplier.
  // On a row wrap x returns to 0 so the next address is just the (possibly advanced) row base.
  always_comb begin
    x_inc        = x_q + XW'(1);
    y_inc        = y_q + YW'(1);
    row_wrap     = (x_q == X_LAST);
    last_pix     = row_wrap && (y_q == Y_LAST);
    row_step     = ((y_inc >> k) != (y_q >> k));
    row_base_nxt = row_base_q + (row_step ? ROW_STEP : '0);
    src_nxt      = row_wrap ? row_base_nxt : (row_base_q + ADDR_W'(x_inc >> k));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    tag_early = tag_vld;
    // The read in the last stage is being written this cycle; only older stages still count as pending.
    tag_early[RD_LATENCY-1] = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (rd_en && last_pix) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (tag_early == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-side scan: destination counters, source row base and the read strobe/address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zoom_q     <= 2'b00;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      dst_addr_q <= '0;
    end else if (accept) begin
      zoom_q     <= fator_zoom;
      rd_en      <= 1'b1;
      rd_addr    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      dst_addr_q <= '0;
    end else if (rd_en) begin
      if (last_pix) begin
        // Address registers hold their last value once the strobe drops.
        rd_en <= 1'b0;
      end else begin
        rd_addr    <= src_nxt;
        dst_addr_q <= dst_addr_q + ADDR_W'(1);
        x_q        <= row_wrap ? '0 : x_inc;
        if (row_wrap) begin
          y_q        <= y_inc;
          row_base_q <= row_base_nxt;
        end
      end
    end
  end

  // Addresses advance only with a valid tag, so wr_addr holds after the last write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_addr[i] <= '0;
    end else begin
      tag_vld[0] <= rd_en;
      if (rd_en) tag_addr[0] <= dst_addr_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        if (tag_vld[i-1]) tag_addr[i] <= tag_addr[i-1];
      end
    end
  end

  assign wr_en   = tag_vld[RD_LATENCY-1];
  assign wr_addr = tag_addr[RD_LATENCY-1];
  assign wr_data = wr_en ? rd_data : '0;

endmodule

// File: tb/tb_zoom_in_nni_scanner.sv
module tb_zoom_in_nni_scanner;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset;

  logic        start1, start3;
  logic [1:0]  zoom1, zoom3;
  logic        busy1, done1, rd_en1, wr_en1;
  logic        busy3, done3, rd_en3, wr_en3;
  logic [14:0] rd_addr1, wr_addr1, rd_addr3, wr_addr3;
  logic [7:0]  rd_data1, wr_data1, rd_data3, wr_data3;
  logic [7:0]  p3a, p3b;

  int n_chk  = 0;
  int n_fail = 0;
  int frames [4][N];

  typedef struct {
    logic [1:0] z;
    int         addr;
    int         exp;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  zoom_in_nni_scanner #(.IMG_W(W), .IMG_H(H), .ADDR_W(15), .DATA_W(8), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .fator_zoom(zoom1),
    .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1));

  zoom_in_nni_scanner #(.IMG_W(W), .IMG_H(H), .ADDR_W(15), .DATA_W(8), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .fator_zoom(zoom3),
    .busy(busy3), .done(done3), .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3));

  // Source RAMs: data = address; 8'hEE when the read strobe was low.
  always @(posedge clk) rd_data1 <= rd_en1 ? rd_addr1[7:0] : 8'hEE;
  always @(posedge clk) begin
    p3a      <= rd_en3 ? rd_addr3[7:0] : 8'hEE;
    p3b      <= p3a;
    rd_data3 <= p3b;
  end

  function automatic int kof(input logic [1:0] z);
    if (z == 2'b01) return 1;
    if (z == 2'b10) return 2;
    return 0;
  endfunction

  // Reference: destination pixel i takes source pixel (x>>k, y>>k).
  function automatic int src_of(input int i, input int k);
    return ((i / W) >> k) * W + ((i % W) >> k);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One frame on the chosen DUT, with optional spurious starts and a mid-frame zoom change.
  task automatic run_frame(input int sel, input logic [1:0] z, input int spur1, input int spur2,
                           input logic [1:0] zc, input int zc_cyc);
    int lat, k, i;
    int rd_cnt, wr_cnt, done_cnt, done_cyc, busy_err, rd_bad, wr_bad;
    logic st;
    logic [1:0] zz;
    logic s_busy, s_done, s_rd_en, s_wr_en;
    int s_rd_addr, s_wr_addr, s_wr_data;
    lat = (sel == 3) ? 3 : 1;
    k = kof(z);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1; busy_err = 0; rd_bad = 0; wr_bad = 0;
    for (int c = 0; c < N + lat + 6; c++) begin
      @(posedge clk); #1;
      st = (c == 0) || (c == spur1) || (c == spur2);
      zz = (c > 0 && c >= zc_cyc) ? zc : z;
      if (sel == 3) begin start3 = st; zoom3 = zz; end
      else          begin start1 = st; zoom1 = zz; end
      @(negedge clk);
      if (sel == 3) begin
        s_busy = busy3; s_done = done3; s_rd_en = rd_en3; s_wr_en = wr_en3;
        s_rd_addr = int'(rd_addr3); s_wr_addr = int'(wr_addr3); s_wr_data = int'(wr_data3);
      end else begin
        s_busy = busy1; s_done = done1; s_rd_en = rd_en1; s_wr_en = wr_en1;
        s_rd_addr = int'(rd_addr1); s_wr_addr = int'(wr_addr1); s_wr_data = int'(wr_data1);
      end
      if (s_busy != (c >= 1 && c <= N + lat)) busy_err++;
      if (s_done) begin done_cnt++; done_cyc = c; end
      if (s_rd_en) begin
        rd_cnt++;
        i = c - 1;
        if (i < 0 || i >= N) rd_bad++;
        else chk("rd_addr", s_rd_addr, src_of(i, k));
      end
      if (s_wr_en) begin
        wr_cnt++;
        i = c - 1 - lat;
        if (i < 0 || i >= N) wr_bad++;
        else begin
          chk("wr_addr", s_wr_addr, i);
          chk("wr_data", s_wr_data, src_of(i, k));
        end
        if (s_wr_addr >= 0 && s_wr_addr < N) frames[z][s_wr_addr] = s_wr_data;
      end
    end
    start1 = 1'b0; start3 = 1'b0;
    chk("rd_count", rd_cnt, N);
    chk("wr_count", wr_cnt, N);
    chk("rd_outside_window", rd_bad, 0);
    chk("wr_outside_window", wr_bad, 0);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_cyc, N + lat + 1);
    chk("busy_window_errors", busy_err, 0);
  endtask

  // Reset asserted mid-frame at cycle 10 must silence the strobes immediately.
  task automatic reset_abort();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      start1 = (c == 0);
      zoom1  = 2'b00;
    end
    @(negedge clk);
    chk("abort_busy_before", int'(busy1), 1);
    chk("abort_rd_en_before", int'(rd_en1), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy1), 0);
    chk("abort_rd_en", int'(rd_en1), 0);
    chk("abort_wr_en", int'(wr_en1), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_idle_rd_en", int'(rd_en1), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b00, 19, 19};
    tbl[1]  = '{2'b00, 31, 31};
    tbl[2]  = '{2'b01, 19, 9};
    tbl[3]  = '{2'b01, 8,  0};
    tbl[4]  = '{2'b01, 11, 1};
    tbl[5]  = '{2'b01, 15, 3};
    tbl[6]  = '{2'b01, 31, 11};
    tbl[7]  = '{2'b10, 3,  0};
    tbl[8]  = '{2'b10, 4,  1};
    tbl[9]  = '{2'b10, 10, 0};
    tbl[10] = '{2'b10, 31, 1};
    tbl[11] = '{2'b11, 26, 26};

    reset = 1'b1;
    start1 = 1'b0; start3 = 1'b0;
    zoom1 = 2'b00; zoom3 = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset_busy",    int'(busy1), 0);
    chk("reset_done",    int'(done1), 0);
    chk("reset_rd_en",   int'(rd_en1), 0);
    chk("reset_wr_en",   int'(wr_en1), 0);
    chk("reset_rd_addr", int'(rd_addr1), 0);
    chk("reset_wr_addr", int'(wr_addr1), 0);
    chk("reset_wr_data", int'(wr_data1), 0);
    chk("reset_busy_l3", int'(busy3), 0);
    @(posedge clk); #1 reset = 1'b0;

    run_frame(1, 2'b00, -1, -1, 2'b00, 9999);
    run_frame(1, 2'b01, -1, -1, 2'b01, 9999);
    run_frame(1, 2'b10, -1, -1, 2'b10, 9999);
    run_frame(1, 2'b11, -1, -1, 2'b11, 9999);
    foreach (tbl[j]) chk($sformatf("table_z%0d_addr%0d", tbl[j].z, tbl[j].addr), frames[tbl[j].z][tbl[j].addr], tbl[j].exp);
    for (int a = 0; a < N; a++)
      if (frames[3][a] != frames[0][a]) chk("fallback_equals_1x", frames[3][a], frames[0][a]);

    run_frame(1, 2'b00, 5, 34, 2'b00, 9999);
    run_frame(1, 2'b01, -1, -1, 2'b10, 7);
    reset_abort();
    run_frame(1, 2'b00, -1, -1, 2'b00, 9999);
    run_frame(3, 2'b01, -1, -1, 2'b01, 9999);

    repeat (6) begin
      int sel, lat;
      logic [1:0] z, zc;
      sel = ($urandom_range(0, 1) == 1) ? 3 : 1;
      lat = (sel == 3) ? 3 : 1;
      z   = 2'($urandom_range(0, 3));
      zc  = 2'($urandom_range(0, 3));
      run_frame(sel, z, $urandom_range(1, N + lat + 1), $urandom_range(1, N + lat + 1),
                zc, $urandom_range(1, 30));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
